// File: rtl/slot_pkg.sv
// Shared types and constants for the three-reel slot sequencer.
package slot_pkg;

  localparam int REEL_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SPIN0  = 3'd1,
    SPIN1  = 3'd2,
    SPIN2  = 3'd3,
    JUDGE  = 3'd4,
    RESULT = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE    = 2'b00;
  localparam logic [1:0] WIN_PAIR    = 2'b01;
  localparam logic [1:0] WIN_JACKPOT = 2'b10;

endpackage

// File: rtl/slot_judge.sv
// Combinational win classifier for three reel digits; also used by the display path.
module slot_judge
  import slot_pkg::*;
(
  input  logic [REEL_W-1:0] reel0,
  input  logic [REEL_W-1:0] reel1,
  input  logic [REEL_W-1:0] reel2,
  output logic [1:0]        win
);

  always_comb begin
    win = WIN_NONE;
    if (reel0 == reel1 && reel1 == reel2) begin
      win = WIN_JACKPOT;
    end else if (reel0 == reel1 || reel1 == reel2 || reel0 == reel2) begin
      win = WIN_PAIR;
    end
  end

endmodule

// File: rtl/slot_ctrl.sv
// Three-reel slot game sequencer: reel enables, stop-on-press, win judging, credits.
//
// state  | meaning
// IDLE   | waiting for a start press (needs credit > 0)
// SPIN0  | all reels spinning, next press stops reel 0
// SPIN1  | reels 1,2 spinning, next press stops reel 1
// SPIN2  | reel 2 spinning, next press stops reel 2
// JUDGE  | one cycle: classify final digits, pay out
// RESULT | show result for RESULT_TICKS ticks, then back to IDLE
module slot_ctrl
  import slot_pkg::*;
#(
  parameter int RESULT_TICKS = 3,
  parameter int INIT_CREDIT  = 10,
  parameter int JACKPOT_PAY  = 10,
  parameter int PAIR_PAY     = 2,
  parameter int CREDIT_MAX   = 99
) (
  input  logic              clk,
  input  logic              i_sclr_n,
  input  logic              i_tick,
  input  logic              i_btn_pulse,
  input  logic [REEL_W-1:0] i_reel0,
  input  logic [REEL_W-1:0] i_reel1,
  input  logic [REEL_W-1:0] i_reel2,
  output logic [2:0]        o_reel_en,
  output logic              o_busy,
  output logic              o_result_vld,
  output logic [1:0]        o_win,
  output logic [6:0]        o_credit
);

  localparam int CNT_W = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;

  state_t           state, state_nxt;
  logic [2:0]       spin_mask;
  logic [CNT_W-1:0] tick_cnt;
  logic [6:0]       credit;
  logic [1:0]       win;
  logic [1:0]       judge_win;
  logic [7:0]       pay;
  logic [7:0]       credit_sum;
  logic [6:0]       credit_paid;
  logic             start;
  logic             last_tick;

  slot_judge u_judge (
    .reel0 (i_reel0),
    .reel1 (i_reel1),
    .reel2 (i_reel2),
    .win   (judge_win)
  );

  assign start     = i_btn_pulse && (credit != 7'd0);
  assign last_tick = i_tick && (tick_cnt == CNT_W'(RESULT_TICKS - 1));

  // Payout is summed at 8 bits so the clamp sees any overshoot past CREDIT_MAX.
  always_comb begin
    pay = 8'd0;
    case (judge_win)
      WIN_JACKPOT: pay = 8'(JACKPOT_PAY);
      WIN_PAIR:    pay = 8'(PAIR_PAY);
      default:     pay = 8'd0;
    endcase
    credit_sum  = {1'b0, credit} + pay;
    credit_paid = (credit_sum > 8'(CREDIT_MAX)) ? 7'(CREDIT_MAX) : credit_sum[6:0];
  end

  always_ff @(posedge clk) begin
    if (!i_sclr_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)       state_nxt = SPIN0;
      SPIN0:   if (i_btn_pulse) state_nxt = SPIN1;
      SPIN1:   if (i_btn_pulse) state_nxt = SPIN2;
      SPIN2:   if (i_btn_pulse) state_nxt = JUDGE;
      JUDGE:                    state_nxt = RESULT;
      RESULT:  if (last_tick)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      spin_mask <= 3'b000;
      tick_cnt  <= '0;
      win       <= WIN_NONE;
      credit    <= 7'(INIT_CREDIT);
    end else begin
      case (state)
        IDLE: if (start) begin
          credit    <= credit - 7'd1;
          spin_mask <= 3'b111;
          win       <= WIN_NONE;
        end
        SPIN0: if (i_btn_pulse) spin_mask[0] <= 1'b0;
        SPIN1: if (i_btn_pulse) spin_mask[1] <= 1'b0;
        SPIN2: if (i_btn_pulse) spin_mask[2] <= 1'b0;
        JUDGE: begin
          win      <= judge_win;
          credit   <= credit_paid;
          tick_cnt <= '0;
        end
        RESULT: if (i_tick) tick_cnt <= tick_cnt + CNT_W'(1);
        default: spin_mask <= 3'b000;
      endcase
    end
  end

  always_comb begin
    o_reel_en    = spin_mask & {3{i_tick}};
    o_busy       = (state != IDLE);
    o_result_vld = (state == RESULT);
    o_win        = win;
    o_credit     = credit;
  end

endmodule

// File: tb/tb_slot_ctrl.sv
// Bench for slot_ctrl: directed game scenarios plus randomized play against a game-level model.
module tb_slot_ctrl;

  localparam int P_IDLE = 0, P_SPIN = 1, P_JUDGE = 2, P_RESULT = 3;

  logic       clk = 1'b0;
  logic       i_sclr_n, i_tick, i_btn_pulse;
  logic [3:0] i_reel0, i_reel1, i_reel2;
  logic [2:0] o_reel_en;
  logic       o_busy, o_result_vld;
  logic [1:0] o_win;
  logic [6:0] o_credit;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] dg0, dg1, dg2;
  logic [2:0] en_obs, en_exp;
  int         m_phase, m_spin, m_ticks, m_credit;
  logic [1:0] m_win;

  slot_ctrl dut (
    .clk          (clk),
    .i_sclr_n     (i_sclr_n),
    .i_tick       (i_tick),
    .i_btn_pulse  (i_btn_pulse),
    .i_reel0      (i_reel0),
    .i_reel1      (i_reel1),
    .i_reel2      (i_reel2),
    .o_reel_en    (o_reel_en),
    .o_busy       (o_busy),
    .o_result_vld (o_result_vld),
    .o_win        (o_win),
    .o_credit     (o_credit)
  );

  always #5 clk = ~clk;

  // One clock: apply inputs, sample the combinational enables, advance the game model, take the edge.
  task automatic cyc(input logic btn, input logic tick);
    int pay;
    i_btn_pulse = btn;
    i_tick      = tick;
    i_reel0     = dg0;
    i_reel1     = dg1;
    i_reel2     = dg2;
    #1;
    en_obs = o_reel_en;
    en_exp = 3'b000;
    if (m_phase == P_SPIN && tick)
      for (int k = 0; k < 3; k++) if (k >= m_spin) en_exp[k] = 1'b1;
    if (!i_sclr_n) begin
      m_phase = P_IDLE; m_credit = 10; m_win = 2'b00; m_spin = 0; m_ticks = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (btn && m_credit > 0) begin
          m_credit = m_credit - 1; m_win = 2'b00; m_phase = P_SPIN; m_spin = 0;
        end
        P_SPIN: if (btn) begin
          m_spin = m_spin + 1;
          if (m_spin == 3) m_phase = P_JUDGE;
        end
        P_JUDGE: begin
          if (dg0 == dg1 && dg1 == dg2) begin m_win = 2'b10; pay = 10; end
          else if (dg0 == dg1 || dg1 == dg2 || dg0 == dg2) begin m_win = 2'b01; pay = 2; end
          else begin m_win = 2'b00; pay = 0; end
          m_credit = (m_credit + pay > 99) ? 99 : m_credit + pay;
          m_phase = P_RESULT; m_ticks = 0;
        end
        default: if (tick) begin
          m_ticks = m_ticks + 1;
          if (m_ticks == 3) m_phase = P_IDLE;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic play_game(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    dg0 = a; dg1 = b; dg2 = c;
    cyc(1, 0); cyc(0, 1); cyc(1, 1); cyc(1, 0); cyc(0, 1); cyc(1, 0);
    cyc(0, 0);
    repeat (3) cyc(0, 1);
  endtask

  task automatic do_reset();
    i_sclr_n = 1'b0;
    cyc(0, 0);
    i_sclr_n = 1'b1;
  endtask

  task automatic test_reset();
    i_sclr_n = 1'b0;
    cyc(0, 0); cyc(0, 1);
    i_sclr_n = 1'b1;
    n_cmp++; if (o_credit !== 7'd10) begin n_bad++; $display("FAIL reset_credit got %0d want 10", o_credit); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_cmp++; if (o_win !== 2'b00) begin n_bad++; $display("FAIL reset_win got %b want 00", o_win); end
    n_cmp++; if (o_result_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", o_result_vld); end
    repeat (3) begin
      cyc(0, 1);
      n_cmp++; if (en_obs !== 3'b000) begin n_bad++; $display("FAIL reset_idle_en got %b want 000", en_obs); end
    end
  endtask

  task automatic test_jackpot();
    int ticks_seen;
    dg0 = 4'd2; dg1 = 4'd5; dg2 = 4'd8;
    cyc(1, 0);
    n_cmp++; if (o_credit !== 7'd9) begin n_bad++; $display("FAIL jp_start_credit got %0d want 9", o_credit); end
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL jp_start_busy got %b want 1", o_busy); end
    cyc(0, 1);
    n_cmp++; if (en_obs !== 3'b111) begin n_bad++; $display("FAIL jp_spin0_en got %b want 111", en_obs); end
    cyc(1, 1);
    n_cmp++; if (en_obs !== 3'b111) begin n_bad++; $display("FAIL jp_stop0_en got %b want 111", en_obs); end
    cyc(0, 1);
    n_cmp++; if (en_obs !== 3'b110) begin n_bad++; $display("FAIL jp_spin1_en got %b want 110", en_obs); end
    cyc(1, 0);
    dg0 = 4'd7; dg1 = 4'd7; dg2 = 4'd7;
    cyc(0, 1);
    n_cmp++; if (en_obs !== 3'b100) begin n_bad++; $display("FAIL jp_spin2_en got %b want 100", en_obs); end
    cyc(1, 1);
    n_cmp++; if (o_credit !== 7'd9 || o_result_vld !== 1'b0 || o_busy !== 1'b1) begin
      n_bad++; $display("FAIL jp_judge_state credit %0d vld %b busy %b want 9 0 1", o_credit, o_result_vld, o_busy);
    end
    cyc(1, 1);
    n_cmp++; if (en_obs !== 3'b000) begin n_bad++; $display("FAIL jp_judge_en got %b want 000", en_obs); end
    n_cmp++; if (o_credit !== 7'd19) begin n_bad++; $display("FAIL jp_credit got %0d want 19", o_credit); end
    n_cmp++; if (o_win !== 2'b10) begin n_bad++; $display("FAIL jp_win got %b want 10", o_win); end
    n_cmp++; if (o_result_vld !== 1'b1) begin n_bad++; $display("FAIL jp_vld got %b want 1", o_result_vld); end
    ticks_seen = 0;
    for (int i = 0; i < 10 && o_result_vld === 1'b1; i++) begin
      if (i % 2 == 1) ticks_seen++;
      cyc(i % 2 == 0, i % 2 == 1);
    end
    n_cmp++; if (ticks_seen != 3) begin n_bad++; $display("FAIL jp_result_ticks got %0d want 3", ticks_seen); end
    n_cmp++; if (o_busy !== 1'b0 || o_credit !== 7'd19 || o_win !== 2'b10) begin
      n_bad++; $display("FAIL jp_after busy %b credit %0d win %b want 0 19 10", o_busy, o_credit, o_win);
    end
  endtask

  task automatic test_pair_lose();
    play_game(4'd3, 4'd5, 4'd3);
    n_cmp++; if (o_win !== 2'b01 || o_credit !== 7'd20) begin
      n_bad++; $display("FAIL pair_353 win %b credit %0d want 01 20", o_win, o_credit);
    end
    play_game(4'd1, 4'd2, 4'd4);
    n_cmp++; if (o_win !== 2'b00 || o_credit !== 7'd19) begin
      n_bad++; $display("FAIL lose_124 win %b credit %0d want 00 19", o_win, o_credit);
    end
    play_game(4'd4, 4'd8, 4'd8);
    n_cmp++; if (o_win !== 2'b01 || o_credit !== 7'd20) begin
      n_bad++; $display("FAIL pair_488 win %b credit %0d want 01 20", o_win, o_credit);
    end
  endtask

  task automatic test_simul();
    dg0 = 4'($urandom_range(0, 9)); dg1 = 4'($urandom_range(0, 9)); dg2 = 4'($urandom_range(0, 9));
    cyc(1, 0); cyc(1, 0);
    cyc(1, 1);
    n_cmp++; if (en_obs !== 3'b110) begin n_bad++; $display("FAIL simul_press_tick_en got %b want 110", en_obs); end
    repeat (3) begin
      cyc(0, 1);
      n_cmp++; if (en_obs !== 3'b100) begin n_bad++; $display("FAIL simul_later_en got %b want 100", en_obs); end
    end
    cyc(1, 0); cyc(0, 0);
    repeat (3) cyc(0, 1);
    n_cmp++; if (o_credit !== 7'(m_credit) || o_busy !== 1'b0) begin
      n_bad++; $display("FAIL simul_end credit %0d busy %b want %0d 0", o_credit, o_busy, m_credit);
    end
  endtask

  task automatic test_credit_bounds();
    for (int g = 0; g < 40 && o_credit !== 7'd0; g++) play_game(4'd1, 4'd2, 4'd4);
    n_cmp++; if (o_credit !== 7'd0) begin n_bad++; $display("FAIL drain_credit got %0d want 0", o_credit); end
    cyc(1, 0);
    n_cmp++; if (o_busy !== 1'b0 || o_credit !== 7'd0) begin
      n_bad++; $display("FAIL zero_press busy %b credit %0d want 0 0", o_busy, o_credit);
    end
    cyc(0, 1);
    n_cmp++; if (en_obs !== 3'b000) begin n_bad++; $display("FAIL zero_en got %b want 000", en_obs); end
    do_reset();
    repeat (9) play_game(4'd7, 4'd7, 4'd7);
    repeat (4) play_game(4'd2, 4'd2, 4'd6);
    n_cmp++; if (o_credit !== 7'd95) begin n_bad++; $display("FAIL reach95 got %0d want 95", o_credit); end
    play_game(4'd9, 4'd9, 4'd9);
    n_cmp++; if (o_credit !== 7'd99 || o_win !== 2'b10) begin
      n_bad++; $display("FAIL sat_jp credit %0d win %b want 99 10", o_credit, o_win);
    end
    play_game(4'd0, 4'd0, 4'd0);
    n_cmp++; if (o_credit !== 7'd99) begin n_bad++; $display("FAIL sat_jp2 got %0d want 99", o_credit); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(1, 0); cyc(1, 0); cyc(1, 0);
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL mid_spin2_busy got %b want 1", o_busy); end
    i_sclr_n = 1'b0;
    cyc(1, 1);
    i_sclr_n = 1'b1;
    n_cmp++; if (o_busy !== 1'b0 || o_credit !== 7'd10 || o_win !== 2'b00) begin
      n_bad++; $display("FAIL mid_spin2_rst busy %b credit %0d win %b want 0 10 00", o_busy, o_credit, o_win);
    end
    cyc(0, 1);
    n_cmp++; if (en_obs !== 3'b000) begin n_bad++; $display("FAIL mid_spin2_en got %b want 000", en_obs); end
    dg0 = 4'd7; dg1 = 4'd7; dg2 = 4'd7;
    cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(1, 0); cyc(0, 0); cyc(0, 1);
    n_cmp++; if (o_result_vld !== 1'b1 || o_credit !== 7'd19) begin
      n_bad++; $display("FAIL mid_result vld %b credit %0d want 1 19", o_result_vld, o_credit);
    end
    i_sclr_n = 1'b0;
    cyc(0, 1);
    i_sclr_n = 1'b1;
    n_cmp++; if (o_busy !== 1'b0 || o_result_vld !== 1'b0 || o_credit !== 7'd10 || o_win !== 2'b00) begin
      n_bad++; $display("FAIL mid_result_rst busy %b vld %b credit %0d win %b want 0 0 10 00",
                        o_busy, o_result_vld, o_credit, o_win);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      i_sclr_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 1) == 0) begin
        dg0 = 4'($urandom_range(0, 2)); dg1 = 4'($urandom_range(0, 2)); dg2 = 4'($urandom_range(0, 2));
      end else begin
        dg0 = 4'($urandom_range(0, 9)); dg1 = 4'($urandom_range(0, 9)); dg2 = 4'($urandom_range(0, 9));
      end
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      n_cmp++; if (en_obs !== en_exp) begin n_bad++; $display("FAIL rnd_en cyc %0d got %b want %b", i, en_obs, en_exp); end
      n_cmp++; if (o_credit !== 7'(m_credit)) begin n_bad++; $display("FAIL rnd_credit cyc %0d got %0d want %0d", i, o_credit, m_credit); end
      n_cmp++; if (o_win !== m_win) begin n_bad++; $display("FAIL rnd_win cyc %0d got %b want %b", i, o_win, m_win); end
      n_cmp++; if (o_busy !== (m_phase != P_IDLE)) begin n_bad++; $display("FAIL rnd_busy cyc %0d got %b", i, o_busy); end
      n_cmp++; if (o_result_vld !== (m_phase == P_RESULT)) begin n_bad++; $display("FAIL rnd_vld cyc %0d got %b", i, o_result_vld); end
    end
    i_sclr_n = 1'b1;
  endtask

  initial begin
    i_sclr_n = 1'b0; i_tick = 1'b0; i_btn_pulse = 1'b0;
    dg0 = 4'd0; dg1 = 4'd0; dg2 = 4'd0;
    i_reel0 = 4'd0; i_reel1 = 4'd0; i_reel2 = 4'd0;
    m_phase = P_IDLE; m_spin = 0; m_ticks = 0; m_credit = 10; m_win = 2'b00;
    test_reset();
    test_jackpot();
    test_pair_lose();
    test_simul();
    test_credit_bounds();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slot_ctrl.md
Name: slot_ctrl

Overview:
Game sequencer for a three-reel slot. It drives the per-reel step enables of three counter10_en instances, and stops the reels one at a time on successive debounced button pulses. It then judges the final digits and runs a saturating credit counter. It sits between the button posedge detector / enable_gen tick and the reel counters and 7-seg decoders.

Parameters:
RESULT_TICKS, 3, number of i_tick pulses the RESULT state is held (>=1)
INIT_CREDIT, 10, credit value after reset
JACKPOT_PAY, 10, credits added when all three reels are equal
PAIR_PAY, 2, credits added when exactly two reels are equal
CREDIT_MAX, 99, credit saturation ceiling (must fit in 7 bits)

Ports:
clk  input  1  system clock
i_sclr_n  input  1  synchronous reset, active-low
i_tick  input  1  one-cycle reel step enable (from enable_gen)
i_btn_pulse  input  1  one-cycle debounced button press (from posedge_detector)
i_reel0  input  4  current digit of reel 0 (0..9)
i_reel1  input  4  current digit of reel 1 (0..9)
i_reel2  input  4  current digit of reel 2 (0..9)
o_reel_en  output  3  per-reel counter enable, bit k drives reel k
o_busy  output  1  high in any state other than IDLE
o_result_vld  output  1  high while in RESULT
o_win  output  2  00 none, 01 pair, 10 jackpot; 11 never driven
o_credit  output  7  current credit count

Behaviour:
- Reset (clk edge with i_sclr_n=0): state=IDLE, spin mask=000, tick counter=0, o_win=00, o_credit=INIT_CREDIT. Reset overrides all other inputs, including mid-game.
- o_reel_en = spin_mask & {3{i_tick}}. This is combinational from the registered mask, so a reel steps only on tick cycles.
- IDLE:
  - btn pulse with credit>0: credit-=1, mask=111, o_win=00, go to SPIN0.
  - btn pulse with credit==0: ignored, stay in IDLE.
- SPIN0 / SPIN1 / SPIN2:
  - btn pulse in SPINk clears mask bit k at the next edge; go to SPIN(k+1), or to JUDGE from SPIN2.
  - If the pulse coincides with i_tick, reel k still steps that cycle (mask is registered). Its post-step value is final.
- JUDGE (exactly 1 cycle; reel values are stable here):
  - All three equal: o_win=10, credit+=JACKPOT_PAY.
  - Exactly two equal: o_win=01, credit+=PAIR_PAY.
  - Otherwise: o_win=00.
  - Credit is added saturating at CREDIT_MAX. Clear the tick counter and go to RESULT.
- RESULT:
  - Count i_tick pulses. On the RESULT_TICKS-th tick go to IDLE at that edge.
  - o_win is held until the next game start.
- Button pulses in JUDGE and RESULT are ignored (not queued).
- Credit arithmetic is done at 8 bits internally, then clamped. Credit never wraps below 0 because a start is refused at 0.
- No state is unreachable: an illegal encoding returns to IDLE on the next edge.

Decomposition:
- Package slot_pkg holds:
  - state enum (IDLE, SPIN0, SPIN1, SPIN2, JUDGE, RESULT)
  - win code constants (WIN_NONE=2'b00, WIN_PAIR=2'b01, WIN_JACKPOT=2'b10)
  - reel digit width constant (4)
- One combinational sub-module, slot_judge: takes the three 4-bit digits and returns the 2-bit win code. It is reused by the display logic for its win indication.
- FSM, mask, tick counter and credit counter stay in slot_ctrl.

Test Plan:
- Reset then idle: hold i_sclr_n=0 for 2 cycles, then release. Expect o_credit=10, o_reel_en=000, o_busy=0, o_win=00; no reel enable on subsequent ticks.
- Jackpot game: press, let reels spin, force reel digits to 7,7,7, press three times. Expect credit 10→9 on start and 9→19 in JUDGE, o_win=10, o_result_vld high for exactly 3 ticks, then IDLE.
- Pair and lose:
  - Final digits 3,5,3: expect o_win=01, credit +2.
  - Final digits 1,2,4: expect o_win=00, credit unchanged after the 1-credit deduction.
- Simultaneous press and tick in SPIN1: o_reel_en[1]=1 that cycle and 0 on all later ticks; o_reel_en[2] keeps pulsing.
- Credit boundaries:
  - Preload credit=0 by playing losing games; a press in IDLE leaves state=IDLE and credit=0.
  - Reach 95 credits, then win a jackpot: credit 94+10 saturates to 99.
- Reset mid-operation: assert i_sclr_n=0 in SPIN2 and in RESULT. Expect IDLE, mask=000, credit=10, o_win=00 on the next edge; presses during JUDGE/RESULT cause no state change.
